stage4_sum_accum: RTL
=====================

STAGE4_SUM_ACCUM -- requirements
Module: stage4_sum_accum

Interface
REQ-001 SHALL have parameter VEC_LEN, default 8, meaning the number of pow2 elements per softmax vector (power of two, 2..64).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the element width, signed Q6.10 matching the stage3 pow2 output.
REQ-003 SHALL have derived localparam SUM_W = DATA_W + log2(VEC_LEN), meaning the unsigned accumulator width (19 at defaults).
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port i_en, input, 1, meaning global enable; when low, all state, counters and outputs hold.
REQ-007 SHALL have port i_valid, input, 1, meaning i_pow_x carries an element from stage3.
REQ-008 SHALL have port i_pow_x, input, DATA_W, meaning the pow2 element, Q6.10.
REQ-009 SHALL have port o_ready, output, 1, meaning the block accepts an element this cycle.
REQ-010 SHALL have port i_ready, input, 1, meaning the downstream divider stage accepts o_pow_x/o_sum this cycle.
REQ-011 SHALL have port o_valid, output, 1, meaning o_pow_x/o_sum hold a replayed element with its vector sum.
REQ-012 SHALL have port o_pow_x, output, DATA_W, meaning the replayed element, unchanged bit-for-bit.
REQ-013 SHALL have port o_sum, output, SUM_W, meaning the unsigned sum of all VEC_LEN elements of the current vector, Q(SUM_W-10).10.
REQ-014 SHALL have port o_last, output, 1, meaning o_valid marks the final element of the vector.

Function
REQ-015 SHALL implement FSM states ACCUM and DRAIN.
- ACCUM: o_ready = i_en.
- DRAIN: o_ready = 0.
REQ-016 SHALL accept an element in ACCUM when i_en && i_valid; on acceptance:
- write the element to buffer entry wr_cnt;
- add it to acc;
- increment wr_cnt.
REQ-017 SHALL add an element with bit DATA_W-1 set to acc as zero, while storing and replaying it unchanged.
REQ-018 SHALL zero-extend elements to SUM_W before addition; no saturation is needed (overflow-free by width).
REQ-019 SHALL, on acceptance of element VEC_LEN-1:
- latch the final sum (acc + element) into the o_sum register;
- clear acc and wr_cnt;
- move to DRAIN on the next edge.
REQ-020 SHALL, in DRAIN, drive o_valid = 1 with o_pow_x = buffer[rd_cnt], starting the cycle after entry (sum latency 1 cycle after the last accept).
REQ-021 SHALL advance rd_cnt only when i_en && i_ready && o_valid; o_pow_x, o_sum and o_last hold stable while i_ready = 0.
REQ-022 SHALL assert o_last when rd_cnt == VEC_LEN-1.
REQ-023 SHALL, on handshake of the o_last element, clear rd_cnt and deassert o_valid, returning to ACCUM (o_ready high the next cycle).
REQ-024 SHALL ignore i_valid while o_ready = 0; upstream holds data (stage3 is stalled via i_en by the top level).
REQ-025 SHALL keep o_sum constant for the whole DRAIN of a vector.

Reset
REQ-026 SHALL, on i_rst_n low, asynchronously force:
- state = ACCUM;
- acc, wr_cnt, rd_cnt = 0;
- o_valid = 0, o_last = 0, o_sum = 0, o_pow_x = 0.
REQ-027 SHALL not clear the buffer contents on reset, and SHALL discard any partial vector on reset mid-ACCUM or mid-DRAIN.
REQ-028 SHALL assert o_ready in the first cycle after release when i_en = 1.

Structure
REQ-029 SHALL take DATA_W, FRAC_W = 10 and the Q6.10 constant ONE = 16'h0400 from the shared softmax package.
REQ-030 SHALL place the element buffer in a sub-module stage4_vec_buffer: VEC_LEN x DATA_W, 1 write port, 1 registered-address read port.

Verification
REQ-031 Eight elements of 0x0400 (1.0) -> o_sum = 0x02000 (8.0); eight o_valid beats of 0x0400; o_last on beat 8.
REQ-032 Elements 0x0400, 0x0200, 0x0100, 0x0080, then four 0x0000 -> o_sum = 0x00780 (1.875); replay order preserved.
REQ-033 Eight elements of 0x7FFF -> o_sum = 0x3FFF8, no wrap. One element of 0x8000 among seven 0x0400 -> o_sum = 0x01C00; 0x8000 still replayed.
REQ-034 i_ready toggling 0/1 during DRAIN -> each element is emitted exactly once and outputs stay stable while stalled; o_ready stays 0 throughout DRAIN.
REQ-035 i_en dropped for 3 cycles mid-ACCUM and mid-DRAIN -> no state change; the final result equals the unstalled run.
REQ-036 i_rst_n pulsed low after 5 accepts -> outputs clear immediately; the next full vector of 0x0400 yields o_sum = 0x02000.

Source files
------------

// File: rtl/stage4_sum_accum_pkg.sv
// stage4_sum_accum_pkg: shared softmax fixed-point constants and stage4 FSM states
package stage4_sum_accum_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam logic [DATA_W-1:0] ONE = 16'h0400;
  typedef enum logic {ACCUM, DRAIN} state_t;
endpackage

// File: rtl/stage4_vec_buffer.sv
// stage4_vec_buffer: one-vector element store with a write port and a registered-address read port
module stage4_vec_buffer #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W = stage4_sum_accum_pkg::DATA_W,
  localparam int AW = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ld,
  input  logic [AW-1:0]     rd_next,
  output logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [VEC_LEN];
  // contents survive reset; only the read pointer is cleared
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_addr <= '0;
    else if (rd_ld) rd_addr <= rd_next;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/stage4_sum_accum.sv
// stage4_sum_accum: sums a softmax pow2 vector, then replays each element alongside the vector sum
module stage4_sum_accum #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W = stage4_sum_accum_pkg::DATA_W,
  localparam int SUM_W = DATA_W + $clog2(VEC_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_pow_x,
  output logic              o_ready,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pow_x,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_last
);
  import stage4_sum_accum_pkg::*;
  localparam int AW = $clog2(VEC_LEN);
  localparam logic [AW-1:0] LAST = AW'(VEC_LEN - 1);
  state_t state, state_nxt;
  logic [SUM_W-1:0] acc, add;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic [DATA_W-1:0] rd_data;
  logic accept, fire, wr_last, rd_last;
  assign o_ready = state == ACCUM && i_en;
  assign accept = o_ready && i_valid;
  assign wr_last = wr_cnt == LAST;
  assign o_valid = state == DRAIN;
  assign rd_last = rd_cnt == LAST;
  assign o_last = o_valid && rd_last;
  assign o_pow_x = o_valid ? rd_data : '0;
  assign fire = i_en && i_ready && o_valid;
  // negative-signed pow2 values are invalid for the sum but are still replayed verbatim
  assign add = i_pow_x[DATA_W-1] ? '0 : SUM_W'(i_pow_x);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ACCUM;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == ACCUM ? (accept && wr_last ? DRAIN : ACCUM)
                               : (fire && rd_last ? ACCUM : DRAIN);
  end
  // power-of-two depth: the counters wrap to zero on the last entry
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      acc <= '0;
      wr_cnt <= '0;
      o_sum <= '0;
    end else if (accept) begin
      acc <= wr_last ? '0 : acc + add;
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) o_sum <= acc + add;
    end
  stage4_vec_buffer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W)) u_buf (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .we(accept),
    .wr_addr(wr_cnt),
    .wr_data(i_pow_x),
    .rd_ld(fire),
    .rd_next(rd_cnt + 1'b1),
    .rd_addr(rd_cnt),
    .rd_data(rd_data)
  );
endmodule
